// File: rtl/dcd_inst_queue.sv
// dcd_inst_queue: FIFO buffer for 66-bit decoded-instruction bundles between
// decode and rename/dispatch. The head entry is unpacked into named fields
// under a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   dcd_inst_in[65:0]   decoded bundle; bit 65 marks it valid for storage
//   flush_in            discard every queued entry (mispredict / loop exit)
//   out_ready_in        downstream consumes the head entry this cycle
//   stall_out           queue full; upstream holds its bundle
//   out_valid_out       head entry present
//   count_out           occupancy, 0..DEPTH
//   *_out fields        combinational slice of the head entry, 0 when empty
//   bck_lp_out          head is a backward branch (branch with imm[7] set)
module dcd_inst_queue #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [65:0]   dcd_inst_in,
   input  logic          flush_in,
   input  logic          out_ready_in,
   output logic          stall_out,
   output logic          out_valid_out,
   output logic [AW:0]   count_out,
   output logic          rs_v_out,
   output logic [3:0]    rs_out,
   output logic          rd_v_out,
   output logic [3:0]    rd_out,
   output logic          rt_v_out,
   output logic [3:0]    rt_out,
   output logic          im_v_out,
   output logic [15:0]   imm_out,
   output logic          ldi_out,
   output logic [1:0]    brn_out,
   output logic          jmp_v_out,
   output logic [1:0]    jmp_out,
   output logic          memrd_out,
   output logic          memwr_out,
   output logic [2:0]    alu_ctrl_out,
   output logic          alu_to_add_out,
   output logic          alu_to_mult_out,
   output logic          alu_to_addr_out,
   output logic          invrt_out,
   output logic          regwr_out,
   output logic          pred_result_out,
   output logic [15:0]   pc_out,
   output logic          bck_lp_out
);

   // Bit 65 is always 1 for stored entries, so only bits 64:0 are kept.
   logic [64:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic [64:0]   head;

   assign stall_out     = (count == (AW+1)'(DEPTH));
   assign out_valid_out = (count != '0);
   assign count_out     = count;

   // Full check uses registered count, so a push while full is dropped even
   // when a pop frees a slot in the same cycle.
   assign push = dcd_inst_in[65] & ~stall_out & ~flush_in;
   assign pop  = out_valid_out & out_ready_in;

   always_ff @(posedge clk) begin
      if (!rst_n || flush_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage has no reset; entries are only observable once counted.
   always_ff @(posedge clk) begin
      if (rst_n && push) mem[wr_ptr] <= dcd_inst_in[64:0];
   end

   always_comb begin
      head = '0;
      if (out_valid_out) head = mem[rd_ptr];
   end

   assign rs_v_out        = head[64];
   assign rs_out          = head[63:60];
   assign rd_v_out        = head[59];
   assign rd_out          = head[58:55];
   assign rt_v_out        = head[54];
   assign rt_out          = head[53:50];
   assign im_v_out        = head[49];
   assign imm_out         = head[48:33];
   assign ldi_out         = head[32];
   assign brn_out         = head[31:30];
   assign jmp_v_out       = head[29];
   assign jmp_out         = head[28:27];
   assign memrd_out       = head[26];
   assign memwr_out       = head[25];
   assign alu_ctrl_out    = head[24:22];
   assign alu_to_add_out  = head[21];
   assign alu_to_mult_out = head[20];
   assign alu_to_addr_out = head[19];
   assign invrt_out       = head[18];
   assign regwr_out       = head[17];
   assign pred_result_out = head[16];
   assign pc_out          = head[15:0];
   assign bck_lp_out      = (head[31:30] != 2'b00) && head[40];

endmodule

// File: tb/tb_dcd_inst_queue.sv
module tb_dcd_inst_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [65:0] dcd_inst_in;
   logic        flush_in;
   logic        out_ready_in;
   logic        stall_out, out_valid_out;
   logic [3:0]  count_out;
   logic        rs_v_out, rd_v_out, rt_v_out, im_v_out, ldi_out, jmp_v_out;
   logic [3:0]  rs_out, rd_out, rt_out;
   logic [15:0] imm_out, pc_out;
   logic [1:0]  brn_out, jmp_out;
   logic        memrd_out, memwr_out;
   logic [2:0]  alu_ctrl_out;
   logic        alu_to_add_out, alu_to_mult_out, alu_to_addr_out;
   logic        invrt_out, regwr_out, pred_result_out, bck_lp_out;

   int checks = 0;
   int failures = 0;
   bit cmp_on = 1'b0;

   // Reference: a plain queue of accepted bundles, head at index 0.
   logic [65:0] mq[$];

   dcd_inst_queue #(.DEPTH(8), .AW(3)) dut (
      .clk(clk), .rst_n(rst_n), .dcd_inst_in(dcd_inst_in), .flush_in(flush_in),
      .out_ready_in(out_ready_in), .stall_out(stall_out), .out_valid_out(out_valid_out),
      .count_out(count_out), .rs_v_out(rs_v_out), .rs_out(rs_out), .rd_v_out(rd_v_out),
      .rd_out(rd_out), .rt_v_out(rt_v_out), .rt_out(rt_out), .im_v_out(im_v_out),
      .imm_out(imm_out), .ldi_out(ldi_out), .brn_out(brn_out), .jmp_v_out(jmp_v_out),
      .jmp_out(jmp_out), .memrd_out(memrd_out), .memwr_out(memwr_out),
      .alu_ctrl_out(alu_ctrl_out), .alu_to_add_out(alu_to_add_out),
      .alu_to_mult_out(alu_to_mult_out), .alu_to_addr_out(alu_to_addr_out),
      .invrt_out(invrt_out), .regwr_out(regwr_out), .pred_result_out(pred_result_out),
      .pc_out(pc_out), .bck_lp_out(bck_lp_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [65:0] mk(input logic [3:0] rs, input logic [3:0] rd,
                                      input logic [15:0] imm, input logic [1:0] brn,
                                      input logic [15:0] pc);
      logic [65:0] b;
      b = {$urandom, $urandom, $urandom};
      b[65]    = 1'b1;
      b[63:60] = rs;
      b[58:55] = rd;
      b[48:33] = imm;
      b[31:30] = brn;
      b[15:0]  = pc;
      return b;
   endfunction

   function automatic logic [65:0] junk();
      logic [65:0] b;
      b = {$urandom, $urandom, $urandom};
      b[65] = 1'b0;
      return b;
   endfunction

   // Apply inputs for one cycle and advance the reference at the edge.
   task automatic step(input logic [65:0] b, input logic fl, input logic rdy);
      bit full;
      dcd_inst_in  = b;
      flush_in     = fl;
      out_ready_in = rdy;
      @(posedge clk);
      if (!rst_n || fl) begin
         mq.delete();
      end else begin
         full = (mq.size() == 8);
         if (rdy && mq.size() > 0) void'(mq.pop_front());
         if (b[65] && !full) mq.push_back(b);
      end
      cmp_on = 1'b1;
      #1;
   endtask

   // Every-cycle comparison of all outputs against the reference queue.
   always @(negedge clk) begin
      if (cmp_on) begin
         logic [65:0] h;
         h = (mq.size() > 0) ? mq[0] : '0;
         chk("stall",  66'(stall_out),     66'(mq.size() == 8));
         chk("valid",  66'(out_valid_out), 66'(mq.size() != 0));
         chk("count",  66'(count_out),     66'(mq.size()));
         chk("fields", {1'b0, rs_v_out, rs_out, rd_v_out, rd_out, rt_v_out, rt_out,
                        im_v_out, imm_out, ldi_out, brn_out, jmp_v_out, jmp_out,
                        memrd_out, memwr_out, alu_ctrl_out, alu_to_add_out,
                        alu_to_mult_out, alu_to_addr_out, invrt_out, regwr_out,
                        pred_result_out, pc_out}, {1'b0, h[64:0]});
         chk("bck_lp", 66'(bck_lp_out),
             66'((mq.size() > 0) && (h[31:30] != 2'b00) && h[40]));
      end
   end

   initial begin
      logic [65:0] b;
      rst_n = 1'b0;
      dcd_inst_in = '0;
      flush_in = 1'b0;
      out_ready_in = 1'b0;

      // Reset then idle
      step(junk(), 1'b0, 1'b0);
      step(junk(), 1'b0, 1'b0);
      chk("rst_count", 66'(count_out), 66'(0));
      chk("rst_valid", 66'(out_valid_out), 66'(0));
      chk("rst_stall", 66'(stall_out), 66'(0));
      chk("rst_pc", 66'(pc_out), 66'(0));
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step(junk(), 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      chk("idle_count", 66'(count_out), 66'(0));

      // Single pass
      step(mk(4'h3, 4'h7, 16'h00A5, 2'b01, 16'h0040), 1'b0, 1'b0);
      chk("sp_valid", 66'(out_valid_out), 66'(1));
      chk("sp_rs", 66'(rs_out), 66'(3));
      chk("sp_rd", 66'(rd_out), 66'(7));
      chk("sp_imm", 66'(imm_out), 66'(16'h00A5));
      chk("sp_bck", 66'(bck_lp_out), 66'(1));
      chk("sp_pc", 66'(pc_out), 66'(16'h0040));
      step(junk(), 1'b0, 1'b0);
      chk("sp_hold_pc", 66'(pc_out), 66'(16'h0040));
      step(junk(), 1'b0, 1'b1);
      chk("sp_empty", 66'(out_valid_out), 66'(0));

      // Fill and stall
      for (int i = 0; i < 9; i++) begin
         step(mk(4'(i), 4'(i), 16'(i), 2'(i), 16'(i)), 1'b0, 1'b0);
         if (i == 7) begin
            chk("fill_stall", 66'(stall_out), 66'(1));
            chk("fill_count", 66'(count_out), 66'(8));
         end
      end
      chk("fill9_count", 66'(count_out), 66'(8));
      for (int i = 0; i < 8; i++) begin
         chk("drain_pc", 66'(pc_out), 66'(i));
         step(junk(), 1'b0, 1'b1);
      end
      chk("drain_empty", 66'(count_out), 66'(0));

      // Wrap-around with steady push+pop
      step(mk(4'h1, 4'h2, 16'h0100, 2'b00, 16'd100), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         chk("wrap_pc", 66'(pc_out), 66'(100 + i));
         step(mk(4'h1, 4'h2, 16'h0100, 2'b00, 16'(101 + i)), 1'b0, 1'b1);
         chk("wrap_count", 66'(count_out), 66'(1));
      end
      step(junk(), 1'b0, 1'b1);

      // Flush priority
      for (int i = 0; i < 5; i++) step(mk(4'h5, 4'h5, 16'h0, 2'b00, 16'(200 + i)), 1'b0, 1'b0);
      chk("pre_flush_count", 66'(count_out), 66'(5));
      step(mk(4'h9, 4'h9, 16'h0, 2'b00, 16'h0BAD), 1'b1, 1'b1);
      chk("flush_count", 66'(count_out), 66'(0));
      chk("flush_valid", 66'(out_valid_out), 66'(0));

      // Full with simultaneous pop
      for (int i = 0; i < 8; i++) step(mk(4'h6, 4'h6, 16'h0, 2'b00, 16'(300 + i)), 1'b0, 1'b0);
      step(mk(4'h6, 4'h6, 16'h0, 2'b00, 16'hBEEF), 1'b0, 1'b1);
      chk("fullpop_count", 66'(count_out), 66'(7));
      chk("fullpop_stall", 66'(stall_out), 66'(0));
      chk("fullpop_head", 66'(pc_out), 66'(301));
      for (int i = 0; i < 7; i++) step(junk(), 1'b0, 1'b1);

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         b = {$urandom, $urandom, $urandom};
         b[65] = ($urandom_range(0, 3) != 0);
         step(b, $urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0);
      end
      rst_n = 1'b1;
      step(junk(), 1'b0, 1'b0);

      @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
